// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : arb_pkg
// Brief   : Shared encodings for the memory-port arbiter and its selector.
// Rev     : 1.0
// ============================================================================
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module : rr_select
// Brief  : Combinational winner picker (round-robin from ptr, or lowest index).
// Rev    : 1.0
// ============================================================================
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               fixed_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               valid_o
);

  always_comb begin
    int          j;
    logic [IW-1:0] idx;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    j           = 0;
    idx         = '0;
    // Scan from the start point, wrapping once around the request vector.
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (fixed_i ? 0 : int'(ptr_i)) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IW'(j);
      if (!valid_o && req_i[idx]) begin
        valid_o         = 1'b1;
        grant_idx_o     = idx;
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : N-requester arbiter sharing one main-memory port, with timeout.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int                    NUM_REQ    = 2,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    ARB_MODE   = 0,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF,
  localparam int                   GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_read_en,
  input  logic [NUM_REQ-1:0]            req_write_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [DATA_WIDTH-1:0]         req_data_out,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr_out,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  output logic                          mem_read_en,
  output logic                          mem_write_en,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic                          mem_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [GW-1:0]          gnt_q, gnt_d, ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     oh_q, oh_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   to_q, to_d;

  logic [NUM_REQ-1:0]     req_vec, win_oh;
  logic [GW-1:0]          win_idx;
  logic                   win_valid;
  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];

  assign req_vec = req_read_en | req_write_en;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[i] = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IW      (GW)
  ) u_rr_select (
    .req_i       (req_vec),
    .ptr_i       (ptr_q),
    .fixed_i     (ARB_MODE == ARB_FIXED),
    .grant_oh_o  (win_oh),
    .grant_idx_o (win_idx),
    .valid_o     (win_valid)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          addr_d  = addr_arr[win_idx];
          wdata_d = data_arr[win_idx];
          op_d    = req_write_en[win_idx] ? OP_WR : OP_RD;
          gnt_d   = win_idx;
          oh_d    = win_oh;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ready) begin
          rdata_d = (op_q == OP_WR) ? '0 : mem_data_in;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          rdata_d = ERR_DATA;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ARB_MODE == ARB_RR)
          ptr_d = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign mem_addr_out = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_read_en  = (state_q == ST_BUSY) && (op_q == OP_RD);
  assign mem_write_en = (state_q == ST_BUSY) && (op_q == OP_WR);
  assign req_ready    = (state_q == ST_RESP) ? oh_q : '0;
  assign req_data_out = rdata_q;
  assign timeout_err  = (state_q == ST_RESP) && to_q;
  assign grant_id     = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Round-robin and fixed-priority instances driven by shared stimulus.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int          N   = 2;
  localparam int          AW  = 16;
  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_read_en, req_write_en;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data_in;
  logic [DW-1:0]   mem_data_in;
  logic            mem_ready;

  // index 0 = round-robin instance, 1 = fixed-priority instance
  logic [DW-1:0] o_rdata [2];
  logic [N-1:0]  o_ready [2];
  logic [AW-1:0] o_maddr [2];
  logic [DW-1:0] o_mdata [2];
  logic          o_rd    [2];
  logic          o_wr    [2];
  logic [0:0]    o_gid   [2];
  logic          o_to    [2];

  mem_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(0),
                     .TIMEOUT(TO), .ERR_DATA(ERR)) u_rr (
    .clk(clk), .reset(reset), .req_read_en(req_read_en), .req_write_en(req_write_en),
    .req_addr(req_addr), .req_data_in(req_data_in), .req_data_out(o_rdata[0]),
    .req_ready(o_ready[0]), .mem_addr_out(o_maddr[0]), .mem_data_out(o_mdata[0]),
    .mem_read_en(o_rd[0]), .mem_write_en(o_wr[0]), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .grant_id(o_gid[0]), .timeout_err(o_to[0]));

  mem_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(1),
                     .TIMEOUT(TO), .ERR_DATA(ERR)) u_fx (
    .clk(clk), .reset(reset), .req_read_en(req_read_en), .req_write_en(req_write_en),
    .req_addr(req_addr), .req_data_in(req_data_in), .req_data_out(o_rdata[1]),
    .req_ready(o_ready[1]), .mem_addr_out(o_maddr[1]), .mem_data_out(o_mdata[1]),
    .mem_read_en(o_rd[1]), .mem_write_en(o_wr[1]), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .grant_id(o_gid[1]), .timeout_err(o_to[1]));

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          delay;   // BUSY cycle index of mem_ready; >= TO means timeout
    logic [31:0] mdata;
    int          g_rr;
    int          g_fx;
  } vec_t;

  int          n_cmp, n_fail;
  int          m_ptr;
  logic [31:0] last_rd [2];

  task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (%s) actual=%0h required=%0h at %0t", name, (m != 0) ? "fx" : "rr", act, exp, $time);
    end
  endtask

  // Spec-level winner choice: scan from ptr modulo N, or from 0 in fixed mode.
  function automatic int pick(input logic [1:0] r, input int ptr, input bit fixed);
    int j;
    for (int k = 0; k < N; k++) begin
      j = fixed ? k : (ptr + k) % N;
      if (((r >> j) & 2'b01) != 2'b00) return j;
    end
    return 0;
  endfunction

  task automatic chk_idle(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ready"}, m, o_ready[m], 0);
      chk({tag, "_en"},    m, {o_rd[m], o_wr[m]}, 0);
      chk({tag, "_tmo"},   m, o_to[m], 0);
      chk({tag, "_rdata"}, m, o_rdata[m], last_rd[m]);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ready"}, m, o_ready[m], 0);
      chk({tag, "_en"},    m, {o_rd[m], o_wr[m]}, 0);
      chk({tag, "_tmo"},   m, o_to[m], 0);
      chk({tag, "_rdata"}, m, o_rdata[m], 0);
      chk({tag, "_maddr"}, m, o_maddr[m], 0);
      chk({tag, "_mdata"}, m, o_mdata[m], 0);
      chk({tag, "_gid"},   m, o_gid[m], 0);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      req_read_en  = '0;
      req_write_en = '0;
      mem_ready    = 1'($urandom_range(0, 1));
      mem_data_in  = $urandom;
      @(negedge clk);
      chk_idle("gap");
    end
  endtask

  // One full transaction, entered and left at a negedge with both DUTs idle.
  task automatic txn(input logic [1:0] rd, input logic [1:0] wr, input logic [15:0] a0,
                     input logic [15:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                     input int delay, input logic [31:0] mdata, input bit chg,
                     input int g_rr, input int g_fx);
    int          g   [2];
    bit          opw [2];
    logic [15:0] ea  [2];
    logic [31:0] ed  [2];
    logic [31:0] er  [2];
    bit          timed;
    g[0]  = g_rr;
    g[1]  = g_fx;
    timed = (delay >= TO);
    for (int m = 0; m < 2; m++) begin
      opw[m] = (g[m] == 1) ? wr[1] : wr[0];
      ea[m]  = (g[m] == 1) ? a1 : a0;
      ed[m]  = (g[m] == 1) ? d1 : d0;
      er[m]  = timed ? ERR : (opw[m] ? 32'h0 : mdata);
    end
    req_read_en  = rd;
    req_write_en = wr;
    req_addr     = {a1, a0};
    req_data_in  = {d1, d0};
    mem_ready    = 1'($urandom_range(0, 1));
    mem_data_in  = $urandom;
    @(negedge clk);
    for (int k = 0; k < TO; k++) begin
      for (int m = 0; m < 2; m++) begin
        chk("busy_rd_en", m, o_rd[m], !opw[m]);
        chk("busy_wr_en", m, o_wr[m], opw[m]);
        chk("busy_maddr", m, o_maddr[m], ea[m]);
        chk("busy_mdata", m, o_mdata[m], ed[m]);
        chk("busy_ready", m, o_ready[m], 0);
        if (k == 0) chk("busy_gid", m, o_gid[m], g[m]);
      end
      mem_ready   = (k == delay);
      mem_data_in = (k == delay) ? mdata : $urandom;
      if (chg) begin
        req_read_en  = 2'($urandom);
        req_write_en = 2'($urandom);
        req_addr     = $urandom;
        req_data_in  = {$urandom, $urandom};
      end
      @(negedge clk);
      if (k == delay) break;
    end
    for (int m = 0; m < 2; m++) begin
      chk("resp_ready", m, o_ready[m], (g[m] == 1) ? 2'b10 : 2'b01);
      chk("resp_rdata", m, o_rdata[m], er[m]);
      chk("resp_tmo",   m, o_to[m], timed);
      chk("resp_gid",   m, o_gid[m], g[m]);
      chk("resp_en",    m, {o_rd[m], o_wr[m]}, 0);
    end
    req_read_en  = '0;
    req_write_en = '0;
    mem_ready    = 1'($urandom_range(0, 1));
    mem_data_in  = $urandom;
    last_rd[0]   = er[0];
    last_rd[1]   = er[1];
    @(negedge clk);
    chk_idle("post");
    m_ptr = (g_rr == N - 1) ? 0 : g_rr + 1;
  endtask

  vec_t tbl [10];

  initial begin
    logic [1:0] rd, wr;
    int         gr, gf;
    n_cmp   = 0;
    n_fail  = 0;
    m_ptr   = 0;
    last_rd = '{default: 32'h0};

    tbl[0] = '{2'b11, 2'b00, 16'h0100, 16'h0200, 32'h1111_0000, 32'h2222_0000, 1, 32'hCAFE_0001, 0, 0};
    tbl[1] = '{2'b11, 2'b00, 16'h0101, 16'h0201, 32'h1111_0001, 32'h2222_0001, 0, 32'hCAFE_0002, 1, 0};
    tbl[2] = '{2'b11, 2'b00, 16'h0102, 16'h0202, 32'h1111_0002, 32'h2222_0002, 2, 32'hCAFE_0003, 0, 0};
    tbl[3] = '{2'b11, 2'b00, 16'h0103, 16'h0203, 32'h1111_0003, 32'h2222_0003, 0, 32'hCAFE_0004, 1, 0};
    tbl[4] = '{2'b01, 2'b00, 16'h0040, 16'h0000, 32'h0,          32'h0,          0, 32'h1234_5678, 0, 0};
    tbl[5] = '{2'b10, 2'b00, 16'h0000, 16'h0300, 32'h0,          32'h3333_0000, 0, 32'h0BAD_F00D, 1, 1};
    tbl[6] = '{2'b10, 2'b10, 16'h0000, 16'h00FF, 32'h0,          32'hA5A5_A5A5, 1, 32'h5A5A_5A5A, 1, 1};
    tbl[7] = '{2'b01, 2'b00, 16'h0777, 16'h0000, 32'h0,          32'h0,        100, 32'h7777_7777, 0, 0};
    tbl[8] = '{2'b11, 2'b01, 16'h0888, 16'h0999, 32'h8888_8888, 32'h9999_9999, 5, 32'h4444_4444, 1, 0};
    tbl[9] = '{2'b00, 2'b11, 16'h0AAA, 16'h0BBB, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 7, 32'h5555_5555, 0, 0};

    reset        = 1'b1;
    req_read_en  = '0;
    req_write_en = '0;
    req_addr     = '0;
    req_data_in  = '0;
    mem_ready    = 1'b0;
    mem_data_in  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");

    for (int i = 0; i < 10; i++)
      txn(tbl[i].rd, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
          tbl[i].delay, tbl[i].mdata, 1'b0, tbl[i].g_rr, tbl[i].g_fx);

    // Reset asserted during the second BUSY cycle.
    req_read_en  = 2'b01;
    req_write_en = 2'b00;
    req_addr     = {16'h0000, 16'h0123};
    req_data_in  = {32'h0, 32'h0000_0042};
    mem_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk("rst_busy_rd_en", m, o_rd[m], 1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    reset        = 1'b0;
    req_read_en  = '0;
    m_ptr        = 0;
    last_rd      = '{default: 32'h0};
    @(negedge clk);
    chk_zero("rst_release");
    txn(2'b11, 2'b00, 16'h0321, 16'h0654, 32'h1, 32'h2, 0, 32'hFEED_0001, 1'b0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      rd = 2'($urandom);
      wr = 2'($urandom);
      if ((rd | wr) == 2'b00) rd = 2'b01 << $urandom_range(0, 1);
      gr = pick(rd | wr, m_ptr, 1'b0);
      gf = pick(rd | wr, 0, 1'b1);
      txn(rd, wr, 16'($urandom), 16'($urandom), $urandom, $urandom,
          $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 1)), gr, gf);
      idle_gap($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
